// File: rtl/shift_register_pkg.sv
// Shared types for the frame shift register: FSM states and shift-direction encoding.
package shift_register_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/frame_shift_register_if.sv
// Control and data bundle of the frame shift register; clk/reset stay separate ports.
interface frame_shift_register_if #(
    parameter int WIDTH = 11
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             shift_en;
    logic             dir;
    logic             serial_in;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             clear;
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic [CW-1:0]    bit_count;
    logic             frame_valid;

    modport master (
        output shift_en, dir, serial_in, load, load_data, clear,
        input  out, serial_out, bit_count, frame_valid
    );

    modport slave (
        input  shift_en, dir, serial_in, load, load_data, clear,
        output out, serial_out, bit_count, frame_valid
    );

endinterface

// File: rtl/frame_bit_counter.sv
// Bits-received counter; tc flags the last bit of a frame so the next inc wraps to zero.
module frame_bit_counter #(
    parameter int MODULUS = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inc,
    input  logic                           clr,
    output logic [$clog2(MODULUS+1)-1:0]   count,
    output logic                           tc
);
    localparam int CW = $clog2(MODULUS + 1);

    assign tc = (count == CW'(MODULUS - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/frame_shift_register.sv
// Bidirectional shift register with start-bit frame detection and a one-cycle frame_valid pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start bit; shifts move data but do not count
// SHIFT | inside a frame; every shift counts until WIDTH bits arrive
module frame_shift_register #(
    parameter int               WIDTH        = 11,
    parameter logic [WIDTH-1:0] RESET_VAL    = '1,
    parameter int               START_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_shift_register_if.slave bus
);
    import shift_register_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] shifted;
    logic             frame_valid_q;
    logic             start_ok;
    logic             shift_go;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CW-1:0]    cnt;

    assign shifted = (bus.dir == DIR_LSB) ? {bus.serial_in, out_q[WIDTH-1:1]}
                                          : {out_q[WIDTH-2:0], bus.serial_in};

    assign start_ok = (START_DETECT == 0) || !bus.serial_in;
    // clear and load outrank a same-cycle shift
    assign shift_go = bus.shift_en && !bus.clear && !bus.load;
    assign cnt_inc  = shift_go && ((state == SHIFT) || start_ok);
    assign cnt_clr  = bus.clear || bus.load;

    frame_bit_counter #(
        .MODULUS (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state         <= IDLE;
            out_q         <= RESET_VAL;
            frame_valid_q <= 1'b0;
        end else if (bus.load) begin
            state         <= IDLE;
            out_q         <= bus.load_data;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (bus.shift_en) begin
                out_q <= shifted;
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (cnt_tc) begin
                            state         <= IDLE;
                            frame_valid_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.bit_count   = cnt;
    assign bus.frame_valid = frame_valid_q;
    assign bus.serial_out  = (bus.dir == DIR_LSB) ? out_q[0] : out_q[WIDTH-1];

endmodule
